// File: rtl/mem_dma_pkg.sv
// rtl/mem_dma_pkg.sv - shared types and helpers for the mem_dma block-copy/fill engine
package mem_dma_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

  // End address of a block, one past its last byte; 18 bits so no command can wrap the compare
  function automatic logic [17:0] span_end(input logic [ADDR_W-1:0] base,
                                           input logic [ADDR_W-1:0] len,
                                           input int step);
    return {2'b00, base} + (18'(len) * 18'(step));
  endfunction

endpackage

// File: rtl/mem_dma_agen.sv
// rtl/mem_dma_agen.sv - source/destination word pointers and remaining-word counter
module mem_dma_agen
  import mem_dma_pkg::*;
#(
  parameter int ADDR_STEP = 2
) (
  input  logic              clockg,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              desc,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  logic [ADDR_W-1:0] count;
  logic              down;
  logic [ADDR_W-1:0] back_off;

  // Descending transfers start on the last word of each block
  assign back_off = ADDR_W'((length - 16'd1) * STEP);

  always_ff @(posedge clockg or posedge rst) begin
    if (rst) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      count   <= '0;
      down    <= 1'b0;
    end else if (load) begin
      src_ptr <= desc ? src_base + back_off : src_base;
      dst_ptr <= desc ? dst_base + back_off : dst_base;
      count   <= length;
      down    <= desc;
    end else if (step) begin
      src_ptr <= down ? src_ptr - STEP : src_ptr + STEP;
      dst_ptr <= down ? dst_ptr - STEP : dst_ptr + STEP;
      count   <= count - 16'd1;
    end
  end

  assign last = (count == 16'd1);

endmodule

// File: rtl/mem_dma.sv
// rtl/mem_dma.sv - block-copy / block-fill initiator on the main-memory port
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int ADDR_STEP = 2
) (
  input  logic              clockg,
  input  logic              rst,
  input  logic              halt_sys,
  input  logic              start,
  input  logic              fill_mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_data_in
);

  dma_state_t        state, state_next;
  logic              fill_q;
  logic              err_q;
  logic [DATA_W-1:0] pattern_q;
  logic [DATA_W-1:0] word_buf;

  logic [17:0]       src_end, dst_end;
  logic              reject, desc, accept;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic              last;

  assign src_end = span_end(src_addr, length, ADDR_STEP);
  assign dst_end = span_end(dst_addr, length, ADDR_STEP);

  assign reject = (length == '0)
               || (!fill_mode && (src_end > 18'h10000))
               || (dst_end > 18'h10000);

  // A forward copy would overwrite source words not yet read when dst lands inside src
  assign desc = !fill_mode && (dst_addr > src_addr) && ({2'b00, dst_addr} < src_end);

  assign accept = (state == IDLE) && start && !halt_sys;

  mem_dma_agen #(.ADDR_STEP(ADDR_STEP)) u_agen (
    .clockg   (clockg),
    .rst      (rst),
    .load     (accept && !reject),
    .step     ((state == WRITE) && !halt_sys),
    .desc     (desc),
    .src_base (src_addr),
    .dst_base (dst_addr),
    .length   (length),
    .src_ptr  (src_ptr),
    .dst_ptr  (dst_ptr),
    .last     (last)
  );

  always_ff @(posedge clockg or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fill_q    <= 1'b0;
      err_q     <= 1'b0;
      pattern_q <= '0;
      word_buf  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        fill_q    <= fill_mode;
        pattern_q <= fill_data;
        err_q     <= reject;
      end
      if ((state == READ) && !halt_sys) begin
        word_buf <= mem_data_in;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (!halt_sys) begin
      case (state)
        IDLE:    if (start) state_next = reject ? DONE : (fill_mode ? WRITE : READ);
        READ:    state_next = WRITE;
        WRITE:   state_next = last ? DONE : (fill_q ? WRITE : READ);
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_address    = '0;
    mem_write_en   = 1'b0;
    mem_write_data = '0;
    case (state)
      READ: mem_address = src_ptr;
      WRITE: begin
        mem_address    = dst_ptr;
        mem_write_en   = !halt_sys;
        mem_write_data = fill_q ? pattern_q : word_buf;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = (state == DONE) && err_q;

endmodule

// File: tb/tb_mem_dma.sv
// tb/tb_mem_dma.sv - directed self-checking bench for mem_dma
module tb_mem_dma;

  logic        clockg;
  logic        rst;
  logic        halt_sys;
  logic        start;
  logic        fill_mode;
  logic [15:0] src_addr, dst_addr, length, fill_data;
  logic        busy, done, err;
  logic [15:0] mem_address;
  logic        mem_write_en;
  logic [15:0] mem_write_data;
  logic [15:0] mem_data_in;

  logic [7:0]  mem [0:65535];

  int          checks = 0;
  int          errors = 0;
  int          lat;
  logic        done_err;
  logic [15:0] first_addr;
  int          h_en_bad;
  logic [15:0] wr_q[$];

  mem_dma #(.ADDR_STEP(2)) dut (
    .clockg         (clockg),
    .rst            (rst),
    .halt_sys       (halt_sys),
    .start          (start),
    .fill_mode      (fill_mode),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .length         (length),
    .fill_data      (fill_data),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .mem_address    (mem_address),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_data_in    (mem_data_in)
  );

  initial clockg = 1'b0;
  always #5 clockg = ~clockg;

  assign mem_data_in = {mem[mem_address], mem[mem_address + 16'd1]};

  always @(posedge clockg) begin
    if (mem_write_en) begin
      mem[mem_address]         = mem_write_data[15:8];
      mem[mem_address + 16'd1] = mem_write_data[7:0];
    end
  end

  function automatic logic [15:0] rd16(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return {mem[a], mem[a1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One command; halt_sys is high for cycles h0 .. h0+hn-1 counted from the start edge
  task automatic run_cmd(input logic fm, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l, input logic [15:0] fd,
                         input int h0, input int hn);
    wr_q.delete();
    lat        = 0;
    done_err   = 1'b0;
    first_addr = 16'hxxxx;
    h_en_bad   = 0;
    @(negedge clockg);
    fill_mode = fm; src_addr = s; dst_addr = d; length = l; fill_data = fd;
    start = 1'b1;
    @(posedge clockg);
    #1 start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clockg);
      halt_sys = (c >= h0) && (c < h0 + hn);
      #1;
      if (c == 1) first_addr = mem_address;
      if (halt_sys && mem_write_en) h_en_bad++;
      if (mem_write_en) wr_q.push_back(mem_address);
      if (done) begin
        lat      = c;
        done_err = err;
        break;
      end
    end
    halt_sys = 1'b0;
    chk("no_timeout", 32'(lat != 0), 32'd1);
    @(negedge clockg);
    #1;
    chk("done_pulse_idle", {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; halt_sys = 1'b0; start = 1'b0; fill_mode = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_data = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'h11; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h22;
    mem[4] = 8'h33; mem[5] = 8'h33; mem[6] = 8'h44; mem[7] = 8'h44;

    #12;
    chk("reset_outputs", {busy, done, err, mem_write_en, mem_address, mem_write_data}, 36'd0);
    @(negedge clockg);
    rst = 1'b0;

    // fill 4 words at 0x0100
    run_cmd(1'b1, 16'h0000, 16'h0100, 16'd4, 16'hA5A5, 0, 0);
    chk("fill_latency", lat, 5);
    chk("fill_err", done_err, 0);
    chk("fill_nwrites", wr_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_q.size()) chk("fill_addr", wr_q[i], 32'h0100 + 2 * i);
      chk("fill_mem", rd16(16'h0100 + 16'(2 * i)), 32'hA5A5);
    end

    // ascending copy 0x0000 -> 0x0200
    run_cmd(1'b0, 16'h0000, 16'h0200, 16'd4, 16'h0000, 0, 0);
    chk("asc_latency", lat, 9);
    chk("asc_err", done_err, 0);
    chk("asc_first_read", first_addr, 32'h0000);
    chk("asc_nwrites", wr_q.size(), 4);
    chk("asc_mem0", rd16(16'h0200), 32'h1111);
    chk("asc_mem1", rd16(16'h0202), 32'h2222);
    chk("asc_mem2", rd16(16'h0204), 32'h3333);
    chk("asc_mem3", rd16(16'h0206), 32'h4444);

    // overlapping copy 0x0000 -> 0x0002 must run descending
    run_cmd(1'b0, 16'h0000, 16'h0002, 16'd4, 16'h0000, 0, 0);
    chk("desc_latency", lat, 9);
    chk("desc_first_read", first_addr, 32'h0006);
    if (wr_q.size() > 0) chk("desc_first_write", wr_q[0], 32'h0008);
    chk("desc_mem0", rd16(16'h0002), 32'h1111);
    chk("desc_mem1", rd16(16'h0004), 32'h2222);
    chk("desc_mem2", rd16(16'h0006), 32'h3333);
    chk("desc_mem3", rd16(16'h0008), 32'h4444);
    chk("desc_src_untouched", rd16(16'h0000), 32'h1111);

    // rejects: zero length, and a fill running past the top of memory
    run_cmd(1'b0, 16'h0000, 16'h0300, 16'd0, 16'h0000, 0, 0);
    chk("rej_len0_latency", lat, 1);
    chk("rej_len0_err", done_err, 1);
    chk("rej_len0_nwrites", wr_q.size(), 0);
    run_cmd(1'b1, 16'h0000, 16'hFFFE, 16'd2, 16'hBEEF, 0, 0);
    chk("rej_top_latency", lat, 1);
    chk("rej_top_err", done_err, 1);
    chk("rej_top_nwrites", wr_q.size(), 0);

    // block ending exactly at the top of memory is legal
    run_cmd(1'b1, 16'h0000, 16'hFFFC, 16'd2, 16'h1234, 0, 0);
    chk("edge_latency", lat, 3);
    chk("edge_err", done_err, 0);
    chk("edge_mem_hi", rd16(16'hFFFE), 32'h1234);

    // fill of 3 with halt held over the second WRITE for 2 cycles
    run_cmd(1'b1, 16'h0000, 16'h0300, 16'd3, 16'h5A5A, 2, 2);
    chk("halt_latency", lat, 6);
    chk("halt_we_low", h_en_bad, 0);
    chk("halt_nwrites", wr_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < wr_q.size()) chk("halt_addr", wr_q[i], 32'h0300 + 2 * i);
    chk("halt_mem", rd16(16'h0304), 32'h5A5A);

    // reset during the second WRITE of an 8-word copy
    @(negedge clockg);
    fill_mode = 1'b0; src_addr = 16'h0000; dst_addr = 16'h0400; length = 16'd8;
    start = 1'b1;
    @(posedge clockg);
    #1 start = 1'b0;
    repeat (4) @(negedge clockg);
    #1;
    chk("rstmid_we_before", {mem_write_en, mem_address}, {1'b1, 16'h0402});
    rst = 1'b1;
    #1;
    chk("rstmid_outputs", {busy, done, err, mem_write_en, mem_address, mem_write_data}, 36'd0);
    @(posedge clockg);
    #1;
    chk("rstmid_first_word", rd16(16'h0400), 32'h1111);
    chk("rstmid_no_partial", rd16(16'h0402), 32'h0000);
    @(negedge clockg);
    rst = 1'b0;
    run_cmd(1'b1, 16'h0000, 16'h0500, 16'd2, 16'h0F0F, 0, 0);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_mem", rd16(16'h0502), 32'h0F0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
